dcache_data_port: RTL and testbench

//  Request front-end for the 64x128 data-array SRAM macro. Turns 64-bit CPU word

---
 rtl/dcache_data_port_if.sv | 32 +++
 rtl/dcache_data_port.sv | 139 +++++++++++++
 tb/tb_dcache_data_port.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_data_port_if.sv
// rtl/dcache_data_port_if.sv - CPU request/response and refill handshake bundle for dcache_data_port
interface dcache_data_port_if #(
  parameter int IDX_W  = 6,
  parameter int WORD_W = 64,
  parameter int LINE_W = 128
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [IDX_W+3:0]      req_addr;
  logic [WORD_W-1:0]     req_wdata;
  logic [WORD_W/8-1:0]   req_wstrb;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [WORD_W-1:0]     resp_rdata;
  logic                  refill_valid;
  logic                  refill_ready;
  logic [IDX_W-1:0]      refill_idx;
  logic [LINE_W-1:0]     refill_data;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
           refill_valid, refill_idx, refill_data,
    input  req_ready, resp_valid, resp_rdata, refill_ready
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
           refill_valid, refill_idx, refill_data,
    output req_ready, resp_valid, resp_rdata, refill_ready
  );
endinterface

// File: rtl/dcache_data_port.sv
// rtl/dcache_data_port.sv - request front-end for the 64x128 dcache data SRAM macro
// Defining DCACHE_PORT_STAT_EN adds accepted read/write/refill counters.
module dcache_data_port #(
  parameter int IDX_W  = 6,
  parameter int WORD_W = 64,
  parameter int LINE_W = 128
) (
  input  logic              clock,
  input  logic              reset,
  dcache_data_port_if.slave bus,
  output logic [IDX_W-1:0]  sram_addr_o,
  output logic              sram_wen_n_o,
  output logic [LINE_W-1:0] sram_bwen_n_o,
  output logic [LINE_W-1:0] sram_wdata_o,
  input  logic [LINE_W-1:0] sram_rdata_i
`ifdef DCACHE_PORT_STAT_EN
  ,
  output logic [31:0]       stat_rd_o,
  output logic [31:0]       stat_wr_o,
  output logic [31:0]       stat_rf_o
`endif
);
  localparam int NB = WORD_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_HOLD} state_t;

  state_t            state_q;
  logic              sel_q;
  logic [WORD_W-1:0] hold_q;
  logic [IDX_W-1:0]  addr_q;

  logic              idle;
  logic              rf_fire;
  logic              rq_fire;
  logic              rd_fire;
  logic              wr_fire;
  logic [WORD_W-1:0] mask_w;
  logic [WORD_W-1:0] rd_word;
  logic              unused_lsb;

  assign idle             = (state_q == S_IDLE) && !reset;
  assign rf_fire          = idle && bus.refill_valid;
  assign rq_fire          = idle && !bus.refill_valid && bus.req_valid;
  assign rd_fire          = rq_fire && !bus.req_write;
  assign wr_fire          = rq_fire && bus.req_write;
  assign bus.refill_ready = idle;
  assign bus.req_ready    = idle && !bus.refill_valid;
  assign rd_word          = sel_q ? sram_rdata_i[LINE_W-1:WORD_W] : sram_rdata_i[WORD_W-1:0];
  assign bus.resp_valid   = !reset && (state_q != S_IDLE);
  assign bus.resp_rdata   = (state_q == S_HOLD) ? hold_q : rd_word;
  assign unused_lsb       = ^bus.req_addr[2:0];

  always_comb begin
    mask_w = '1;
    for (int b = 0; b < NB; b++) begin
      mask_w[b*8 +: 8] = {8{~bus.req_wstrb[b]}};
    end
  end

  // Address is held between accesses so the macro pins only toggle on real issues.
  always_comb begin
    sram_addr_o   = addr_q;
    sram_wen_n_o  = 1'b1;
    sram_bwen_n_o = '1;
    sram_wdata_o  = '0;
    if (rf_fire) begin
      sram_addr_o   = bus.refill_idx;
      sram_wen_n_o  = 1'b0;
      sram_bwen_n_o = '0;
      sram_wdata_o  = bus.refill_data;
    end else if (rq_fire) begin
      sram_addr_o = bus.req_addr[IDX_W+3:4];
      if (bus.req_write) begin
        sram_wen_n_o  = 1'b0;
        sram_wdata_o  = {2{bus.req_wdata}};
        sram_bwen_n_o = bus.req_addr[3] ? {mask_w, {WORD_W{1'b1}}}
                                        : {{WORD_W{1'b1}}, mask_w};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      hold_q  <= '0;
      addr_q  <= '0;
    end else begin
      if (rf_fire || rq_fire) begin
        addr_q <= sram_addr_o;
      end
      case (state_q)
        S_IDLE: begin
          if (rd_fire) begin
            sel_q   <= bus.req_addr[3];
            state_q <= S_RD;
          end
        end
        // Macro Q is only valid this cycle, so park it if the consumer stalls.
        S_RD: begin
          if (bus.resp_ready) begin
            state_q <= S_IDLE;
          end else begin
            hold_q  <= rd_word;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.resp_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef DCACHE_PORT_STAT_EN
  logic [31:0] stat_rd_q;
  logic [31:0] stat_wr_q;
  logic [31:0] stat_rf_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
      stat_rf_q <= '0;
    end else begin
      if (rd_fire) stat_rd_q <= stat_rd_q + 32'd1;
      if (wr_fire) stat_wr_q <= stat_wr_q + 32'd1;
      if (rf_fire) stat_rf_q <= stat_rf_q + 32'd1;
    end
  end

  assign stat_rd_o = stat_rd_q;
  assign stat_wr_o = stat_wr_q;
  assign stat_rf_o = stat_rf_q;
`endif
endmodule

// File: tb/tb_dcache_data_port.sv
// tb/tb_dcache_data_port.sv - directed and randomized checks of dcache_data_port against a line-level model
`timescale 1ns/1ps
module tb_dcache_data_port;
  localparam int IDX_W  = 6;
  localparam int WORD_W = 64;
  localparam int LINE_W = 128;
  localparam int LINES  = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dcache_data_port_if #(.IDX_W(IDX_W), .WORD_W(WORD_W), .LINE_W(LINE_W)) bus ();

  logic [IDX_W-1:0]  sram_addr;
  logic              sram_wen_n;
  logic [LINE_W-1:0] sram_bwen_n;
  logic [LINE_W-1:0] sram_wdata;
  logic [LINE_W-1:0] sram_rdata;
`ifdef DCACHE_PORT_STAT_EN
  logic [31:0] stat_rd;
  logic [31:0] stat_wr;
  logic [31:0] stat_rf;
`endif

  dcache_data_port #(.IDX_W(IDX_W), .WORD_W(WORD_W), .LINE_W(LINE_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .sram_addr_o   (sram_addr),
    .sram_wen_n_o  (sram_wen_n),
    .sram_bwen_n_o (sram_bwen_n),
    .sram_wdata_o  (sram_wdata),
    .sram_rdata_i  (sram_rdata)
`ifdef DCACHE_PORT_STAT_EN
    ,
    .stat_rd_o     (stat_rd),
    .stat_wr_o     (stat_wr),
    .stat_rf_o     (stat_rf)
`endif
  );

  // SRAM macro: bit-masked write, Q valid the cycle after a read, 0 after a write.
  logic [LINE_W-1:0] macro_mem [LINES] = '{default: '0};
  always @(posedge clock) begin
    if (!sram_wen_n) begin
      macro_mem[sram_addr] <= (macro_mem[sram_addr] & sram_bwen_n) | (sram_wdata & ~sram_bwen_n);
      sram_rdata <= '0;
    end else begin
      sram_rdata <= macro_mem[sram_addr];
    end
  end

  // Reference: line contents, one outstanding read and its expected word.
  logic [LINE_W-1:0] ref_mem [LINES] = '{default: '0};
  bit                busy = 1'b0;
  logic [WORD_W-1:0] pend_data = '0;
  logic [IDX_W-1:0]  last_addr = '0;
  bit                addr_known = 1'b0;
  int unsigned       n_rd = 0;
  int unsigned       n_wr = 0;
  int unsigned       n_rf = 0;

  int n_vec = 0;
  int n_err = 0;

  logic              s_req_ready;
  logic              s_resp_valid;
  logic              s_wen_n;
  logic [WORD_W-1:0] s_rdata;

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Caller sets inputs just after an edge; outputs are checked mid-cycle, then the model advances.
  task automatic step();
    logic [IDX_W-1:0]  ridx;
    logic              rsel;
    int                sel_base;
    logic [LINE_W-1:0] exp_bwen;
    #3;
    s_req_ready  = bus.req_ready;
    s_resp_valid = bus.resp_valid;
    s_wen_n      = sram_wen_n;
    s_rdata      = bus.resp_rdata;
    ridx         = bus.req_addr[IDX_W+3:4];
    rsel         = bus.req_addr[3];
    sel_base     = rsel ? WORD_W : 0;
    if (reset) begin
      check1("rst_req_ready", bus.req_ready, 1'b0);
      check1("rst_refill_ready", bus.refill_ready, 1'b0);
      check1("rst_resp_valid", bus.resp_valid, 1'b0);
      check1("rst_wen_n", sram_wen_n, 1'b1);
      checkw("rst_bwen_n", sram_bwen_n, '1);
      busy = 1'b0;
      addr_known = 1'b0;
      n_rd = 0; n_wr = 0; n_rf = 0;
    end else if (busy) begin
      check1("busy_req_ready", bus.req_ready, 1'b0);
      check1("busy_refill_ready", bus.refill_ready, 1'b0);
      check1("busy_resp_valid", bus.resp_valid, 1'b1);
      checkw("resp_rdata", LINE_W'(bus.resp_rdata), LINE_W'(pend_data));
      check1("busy_wen_n", sram_wen_n, 1'b1);
      checkw("busy_bwen_n", sram_bwen_n, '1);
      checkw("busy_wdata", sram_wdata, '0);
      if (addr_known) checkw("busy_addr", LINE_W'(sram_addr), LINE_W'(last_addr));
      if (bus.resp_ready) busy = 1'b0;
    end else begin
      check1("idle_refill_ready", bus.refill_ready, 1'b1);
      check1("idle_req_ready", bus.req_ready, !bus.refill_valid);
      check1("idle_resp_valid", bus.resp_valid, 1'b0);
      if (bus.refill_valid) begin
        check1("rf_wen_n", sram_wen_n, 1'b0);
        checkw("rf_addr", LINE_W'(sram_addr), LINE_W'(bus.refill_idx));
        checkw("rf_bwen_n", sram_bwen_n, '0);
        checkw("rf_wdata", sram_wdata, bus.refill_data);
        ref_mem[bus.refill_idx] = bus.refill_data;
        last_addr = bus.refill_idx;
        addr_known = 1'b1;
        n_rf++;
      end else if (bus.req_valid) begin
        checkw("rq_addr", LINE_W'(sram_addr), LINE_W'(ridx));
        last_addr = ridx;
        addr_known = 1'b1;
        if (bus.req_write) begin
          for (int b = 0; b < LINE_W; b++) begin
            exp_bwen[b] = !(((b / WORD_W) == int'(rsel)) && bus.req_wstrb[(b % WORD_W) / 8]);
          end
          check1("wr_wen_n", sram_wen_n, 1'b0);
          checkw("wr_wdata", sram_wdata, {bus.req_wdata, bus.req_wdata});
          checkw("wr_bwen_n", sram_bwen_n, exp_bwen);
          for (int i = 0; i < WORD_W / 8; i++) begin
            if (bus.req_wstrb[i]) ref_mem[ridx][sel_base + i*8 +: 8] = bus.req_wdata[i*8 +: 8];
          end
          n_wr++;
        end else begin
          check1("rd_wen_n", sram_wen_n, 1'b1);
          pend_data = rsel ? ref_mem[ridx][LINE_W-1:WORD_W] : ref_mem[ridx][WORD_W-1:0];
          busy = 1'b1;
          n_rd++;
        end
      end else begin
        check1("nop_wen_n", sram_wen_n, 1'b1);
        checkw("nop_bwen_n", sram_bwen_n, '1);
        checkw("nop_wdata", sram_wdata, '0);
        if (addr_known) checkw("nop_addr", LINE_W'(sram_addr), LINE_W'(last_addr));
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.refill_valid = 1'b0;
    bus.resp_ready   = 1'b1;
  endtask

  task automatic rd(input logic [IDX_W+3:0] a);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = a;
  endtask

  task automatic wr(input logic [IDX_W+3:0] a, input logic [WORD_W-1:0] d, input logic [7:0] s);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wstrb = s;
  endtask

  initial begin
    quiet();
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.req_wstrb   = '0;
    bus.refill_idx  = '0;
    bus.refill_data = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Refill line 5, read upper word back
    bus.refill_valid = 1'b1;
    bus.refill_idx   = 6'd5;
    bus.refill_data  = 128'h0011223344556677_8899AABBCCDDEEFF;
    step();
    quiet();
    rd(10'h058);
    step();
    check1("t1_accept", s_req_ready, 1'b1);
    quiet();
    step();
    check1("t1_resp_valid", s_resp_valid, 1'b1);
    checkw("t1_rdata", LINE_W'(s_rdata), LINE_W'(64'h0011223344556677));

    // Partial write onto the refilled line, then read back
    wr(10'h050, 64'hAABBCCDDEEFF0011, 8'h0F);
    step();
    rd(10'h050);
    step();
    quiet();
    step();
    checkw("t2_rdata", LINE_W'(s_rdata), LINE_W'(64'h8899AABBEEFF0011));

    // Zero-strobe write leaves the line intact
    wr(10'h058, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    step();
    rd(10'h058);
    step();
    quiet();
    step();
    checkw("t2b_rdata", LINE_W'(s_rdata), LINE_W'(64'h0011223344556677));

    // Stalled consumer
    bus.resp_ready = 1'b0;
    rd(10'h058);
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      check1("t3_resp_valid", s_resp_valid, 1'b1);
      check1("t3_req_ready", s_req_ready, 1'b0);
      checkw("t3_rdata", LINE_W'(s_rdata), LINE_W'(64'h0011223344556677));
    end
    quiet();
    step();
    check1("t3_last_valid", s_resp_valid, 1'b1);
    step();
    check1("t3_ready_back", s_req_ready, 1'b1);

    // Refill beats a same-cycle request
    bus.refill_valid = 1'b1;
    bus.refill_idx   = 6'd9;
    bus.refill_data  = 128'hFEDCBA9876543210_0123456789ABCDEF;
    rd(10'h090);
    step();
    check1("t4_req_stalled", s_req_ready, 1'b0);
    check1("t4_refill_wen", s_wen_n, 1'b0);
    bus.refill_valid = 1'b0;
    step();
    check1("t4_req_accept", s_req_ready, 1'b1);
    quiet();
    step();
    checkw("t4_rdata", LINE_W'(s_rdata), LINE_W'(64'h0123456789ABCDEF));

    // Reset while a read is in flight
    rd(10'h058);
    step();
    quiet();
    reset = 1'b1;
    step();
    check1("t5_in_reset_valid", s_resp_valid, 1'b0);
    reset = 1'b0;
    step();
    check1("t5_after_valid", s_resp_valid, 1'b0);
    check1("t5_after_wen", s_wen_n, 1'b1);
    step();
    check1("t5_after_valid2", s_resp_valid, 1'b0);

`ifdef DCACHE_PORT_STAT_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkw("t6_rd_zero", LINE_W'(stat_rd), '0);
    checkw("t6_wr_zero", LINE_W'(stat_wr), '0);
    checkw("t6_rf_zero", LINE_W'(stat_rf), '0);
    bus.refill_valid = 1'b1;
    bus.refill_idx   = 6'd2;
    step();
    quiet();
    wr(10'h020, 64'h1, 8'h01);
    step();
    wr(10'h028, 64'h2, 8'h80);
    step();
    for (int k = 0; k < 3; k++) begin
      rd(10'h020);
      step();
      quiet();
      step();
    end
    checkw("t6_rd", LINE_W'(stat_rd), LINE_W'(32'd3));
    checkw("t6_wr", LINE_W'(stat_wr), LINE_W'(32'd2));
    checkw("t6_rf", LINE_W'(stat_rf), LINE_W'(32'd1));
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      reset            = ($urandom_range(0, 99) < 2);
      bus.refill_valid = ($urandom_range(0, 99) < 20);
      bus.refill_idx   = IDX_W'($urandom_range(0, 7));
      bus.refill_data  = {$urandom, $urandom, $urandom, $urandom};
      bus.req_valid    = ($urandom_range(0, 99) < 60);
      bus.req_write    = 1'($urandom_range(0, 1));
      bus.req_addr     = {IDX_W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))};
      bus.req_wdata    = {$urandom, $urandom};
      bus.req_wstrb    = 8'($urandom);
      bus.resp_ready   = ($urandom_range(0, 99) < 60);
      step();
    end
    reset = 1'b0;
    quiet();
    step();
    step();
`ifdef DCACHE_PORT_STAT_EN
    checkw("stat_rd_model", LINE_W'(stat_rd), LINE_W'(n_rd));
    checkw("stat_wr_model", LINE_W'(stat_wr), LINE_W'(n_wr));
    checkw("stat_rf_model", LINE_W'(stat_rf), LINE_W'(n_rf));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
